// File: rtl/game_pkg.sv
// Shared enemy/collision definitions and the scheduler state encoding.
package game_pkg;

    localparam int unsigned ENEMY_STATE_W = 32;

    // Packed enemy state field offsets: {x[9:0], y[9:0], spd[4:0], 5'b0, dir, 1'b0}
    localparam int unsigned X_LSB   = 22;
    localparam int unsigned Y_LSB   = 12;
    localparam int unsigned SPD_LSB = 7;
    localparam int unsigned DIR_BIT = 1;

    localparam int unsigned COL_LEFT  = 0;
    localparam int unsigned COL_UP    = 1;
    localparam int unsigned COL_RIGHT = 2;
    localparam int unsigned COL_DOWN  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StIssue,
        StWait,
        StNext,
        StCommit
    } sched_state_t;

endpackage

// File: rtl/slot_mux.sv
// Combinational N:1 selector of one packed enemy state by slot index.
module slot_mux
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY = 4,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [ENEMY_STATE_W*N_ENEMY-1:0] i_state_vec,
    input  logic [IDX_W-1:0]                 i_idx,
    output logic [ENEMY_STATE_W-1:0]         o_state
);

    always_comb begin
        o_state = '0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_state = i_state_vec[i*ENEMY_STATE_W +: ENEMY_STATE_W];
            end
        end
    end

endmodule

// File: rtl/enemy_col_scheduler.sv
// Shares one tile-collision checker among N_ENEMY enemies: sweeps the enabled slots on each
// frame tick and publishes every collision nibble at once alongside a one-cycle enemy_step.
module enemy_col_scheduler
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY = 4,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                             sim_clk,
    input  logic                             reset,
    input  logic                             frame_tick,
    input  logic [N_ENEMY-1:0]               slot_en,
    input  logic [ENEMY_STATE_W*N_ENEMY-1:0] enemy_state,
    output logic                             q_valid,
    input  logic                             q_ready,
    output logic [IDX_W-1:0]                 q_idx,
    output logic [ENEMY_STATE_W-1:0]         q_state,
    input  logic                             r_valid,
    input  logic [3:0]                       r_col,
    output logic [4*N_ENEMY-1:0]             enemy_col,
    output logic                             enemy_step,
    output logic                             busy,
    input  logic                             err_clr,
    output logic                             err_overrun,
    output logic                             err_timeout
);

    sched_state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [7:0]                 r_wait_cnt;
    logic [4*N_ENEMY-1:0]       r_col_buf, r_enemy_col;
    logic [ENEMY_STATE_W-1:0]   r_q_state, w_sel_state;
    logic                       r_err_overrun, r_err_timeout;
    logic                       w_slot_en, w_last, w_timeout;
    logic                       w_buf_we, w_set_timeout;
    logic [3:0]                 w_buf_din;

    slot_mux #(
        .N_ENEMY (N_ENEMY),
        .IDX_W   (IDX_W)
    ) u_slot_mux (
        .i_state_vec (enemy_state),
        .i_idx       (r_idx),
        .o_state     (w_sel_state)
    );

    always_comb begin
        w_slot_en = 1'b0;
        for (int i = 0; i < int'(N_ENEMY); i++) begin
            if (r_idx == IDX_W'(i)) w_slot_en = slot_en[i];
        end
    end

    assign w_last    = (r_idx == IDX_W'(N_ENEMY - 1));
    assign w_timeout = (r_wait_cnt == 8'(TIMEOUT));

    always_comb begin
        w_state_nxt   = r_state;
        w_buf_we      = 1'b0;
        w_buf_din     = 4'b0;
        w_set_timeout = 1'b0;
        unique case (r_state)
            StIdle: if (frame_tick) w_state_nxt = StSel;
            StSel: begin
                if (w_slot_en) begin
                    w_state_nxt = StIssue;
                end else begin
                    w_state_nxt = StNext;
                    w_buf_we    = 1'b1;
                end
            end
            StIssue: if (q_ready) w_state_nxt = StWait;
            StWait: begin
                // A response arriving on the timeout cycle still counts.
                if (r_valid) begin
                    w_state_nxt = StNext;
                    w_buf_we    = 1'b1;
                    w_buf_din   = r_col;
                end else if (w_timeout) begin
                    w_state_nxt   = StNext;
                    w_buf_we      = 1'b1;
                    w_set_timeout = 1'b1;
                end
            end
            StNext:   w_state_nxt = w_last ? StCommit : StSel;
            StCommit: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sim_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_col_buf     <= '0;
            r_enemy_col   <= '0;
            r_q_state     <= '0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && frame_tick) r_idx <= '0;
            if (r_state == StNext && !w_last)    r_idx <= r_idx + IDX_W'(1);
            if (r_state == StSel && w_slot_en)   r_q_state <= w_sel_state;
            if (r_state == StIssue && q_ready) begin
                r_wait_cnt <= '0;
            end else if (r_state == StWait && r_wait_cnt != 8'hFF) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            for (int i = 0; i < int'(N_ENEMY); i++) begin
                if (w_buf_we && r_idx == IDX_W'(i)) r_col_buf[4*i +: 4] <= w_buf_din;
            end
            // Load on the edge entering COMMIT so enemy_col is already settled under enemy_step.
            if (r_state == StNext && w_last) r_enemy_col <= r_col_buf;
            r_err_overrun <= (r_err_overrun & ~err_clr) | (frame_tick & (r_state != StIdle));
            r_err_timeout <= (r_err_timeout & ~err_clr) | w_set_timeout;
        end
    end

    assign q_valid     = (r_state == StIssue);
    assign q_idx       = r_idx;
    assign q_state     = r_q_state;
    assign enemy_col   = r_enemy_col;
    assign enemy_step  = (r_state == StCommit);
    assign busy        = (r_state != StIdle);
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_enemy_col_scheduler.sv
// Randomized bench for enemy_col_scheduler: a bench-side checker responder plus a
// sweep-level model of expected nibbles, query order, latency and error flags.
module tb_enemy_col_scheduler;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int T  = 63;

    logic            sim_clk = 1'b0;
    logic            reset;
    logic            frame_tick;
    logic [N-1:0]    slot_en;
    logic [32*N-1:0] enemy_state;
    logic            q_valid;
    logic            q_ready;
    logic [IW-1:0]   q_idx;
    logic [31:0]     q_state;
    logic            r_valid;
    logic [3:0]      r_col;
    logic [4*N-1:0]  enemy_col;
    logic            enemy_step;
    logic            busy;
    logic            err_clr;
    logic            err_overrun;
    logic            err_timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cyc [N];
    int          resp_dly  [N];   // 0 = never respond
    logic [3:0]  resp_col  [N];
    logic [31:0] exp_state [N];
    int          q_log  [$];
    logic [31:0] qs_log [$];
    int          step_cnt = 0;
    logic        exp_to  = 1'b0;
    logic        exp_ovr = 1'b0;

    enemy_col_scheduler #(
        .N_ENEMY (N),
        .IDX_W   (IW),
        .TIMEOUT (T)
    ) dut (
        .sim_clk     (sim_clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .slot_en     (slot_en),
        .enemy_state (enemy_state),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_idx       (q_idx),
        .q_state     (q_state),
        .r_valid     (r_valid),
        .r_col       (r_col),
        .enemy_col   (enemy_col),
        .enemy_step  (enemy_step),
        .busy        (busy),
        .err_clr     (err_clr),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 sim_clk = ~sim_clk;

    always @(negedge sim_clk) if (enemy_step) step_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checker model: stalls ready per slot, then answers resp_dly cycles after acceptance.
    initial begin : responder
        int idx;
        q_ready = 1'b0;
        r_valid = 1'b0;
        r_col   = 4'h0;
        forever begin
            @(negedge sim_clk);
            if (q_valid) begin
                idx = int'(q_idx) % N;
                repeat (stall_cyc[idx]) @(negedge sim_clk);
                q_log.push_back(int'(q_idx));
                qs_log.push_back(q_state);
                q_ready = 1'b1;
                @(posedge sim_clk);
                #1;
                q_ready = 1'b0;
                if (resp_dly[idx] > 0) begin
                    repeat (resp_dly[idx] - 1) @(posedge sim_clk);
                    if (resp_dly[idx] > 1) #1;
                    r_valid = 1'b1;
                    r_col   = resp_col[idx];
                    @(posedge sim_clk);
                    #1;
                    r_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_states();
        for (int i = 0; i < N; i++) begin
            exp_state[i] = $urandom;
            enemy_state[32*i +: 32] = exp_state[i];
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < N; i++) begin
            stall_cyc[i] = 0;
            resp_dly[i]  = 1;
            resp_col[i]  = 4'(1 << i);
        end
    endtask

    task automatic pulse_clr();
        @(posedge sim_clk);
        #1 err_clr = 1'b1;
        @(posedge sim_clk);
        #1 err_clr = 1'b0;
        exp_to  = 1'b0;
        exp_ovr = 1'b0;
        @(negedge sim_clk);
        check_eq("clr.err_timeout", 32'(err_timeout), 32'd0);
        check_eq("clr.err_overrun", 32'(err_overrun), 32'd0);
    endtask

    task automatic wait_query(input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge sim_clk);
            if (q_valid && q_idx == IW'(idx)) ok = 1'b1;
        end
    endtask

    // One full sweep; cycle 1 is the cycle in which frame_tick is high.
    task automatic run_sweep(input string tag, input logic [N-1:0] en);
        logic [4*N-1:0] exp_col;
        int exp_lat;
        int exp_q [$];
        int n;
        bit got;
        int d_eff;
        int steps0;
        exp_col = '0;
        exp_lat = 2;
        n       = 0;
        got     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                exp_q.push_back(i);
                if (resp_dly[i] == 0 || resp_dly[i] > T + 1) begin
                    d_eff  = T + 1;
                    exp_to = 1'b1;
                end else begin
                    d_eff = resp_dly[i];
                    exp_col[4*i +: 4] = resp_col[i];
                end
                exp_lat += 3 + stall_cyc[i] + d_eff;
            end else begin
                exp_lat += 2;
            end
        end
        q_log.delete();
        qs_log.delete();
        @(posedge sim_clk);
        #1;
        slot_en    = en;
        steps0     = step_cnt;
        frame_tick = 1'b1;
        while (!got && n < 3000) begin
            @(negedge sim_clk);
            n++;
            if (enemy_step) begin
                got = 1'b1;
            end else begin
                @(posedge sim_clk);
                #1 frame_tick = 1'b0;
            end
        end
        frame_tick = 1'b0;
        check_eq({tag, ".step_seen"}, 32'(got), 32'd1);
        check_eq({tag, ".latency"}, 32'(n), 32'(exp_lat));
        @(negedge sim_clk);
        #1;
        check_eq({tag, ".enemy_col"}, 32'(enemy_col), 32'(exp_col));
        check_eq({tag, ".step_pulses"}, 32'(step_cnt - steps0), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".err_timeout"}, 32'(err_timeout), 32'(exp_to));
        check_eq({tag, ".err_overrun"}, 32'(err_overrun), 32'(exp_ovr));
        check_eq({tag, ".n_queries"}, 32'(q_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < q_log.size(); k++) begin
            check_eq({tag, ".q_idx"}, 32'(q_log[k]), 32'(exp_q[k]));
            check_eq({tag, ".q_state"}, qs_log[k], exp_state[exp_q[k]]);
        end
    endtask

    initial begin : main
        bit ok;
        int s0;
        reset       = 1'b0;
        frame_tick  = 1'b1;
        err_clr     = 1'b0;
        slot_en     = '1;
        enemy_state = '0;
        set_defaults();
        set_states();

        // Reset held three cycles with a tick present.
        repeat (3) @(negedge sim_clk);
        check_eq("rst.q_valid", 32'(q_valid), 32'd0);
        check_eq("rst.q_idx", 32'(q_idx), 32'd0);
        check_eq("rst.q_state", q_state, 32'd0);
        check_eq("rst.enemy_col", 32'(enemy_col), 32'd0);
        check_eq("rst.enemy_step", 32'(enemy_step), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.errors", {30'd0, err_overrun, err_timeout}, 32'd0);
        @(posedge sim_clk);
        #1;
        frame_tick = 1'b0;
        reset      = 1'b1;
        @(negedge sim_clk);
        check_eq("rst.tick_ignored", 32'(busy), 32'd0);

        // Full sweep with nibbles 1,2,4,8.
        run_sweep("full", 4'b1111);
        check_eq("full.col_8421", 32'(enemy_col), 32'h8421);

        // Stale buffer then partially enabled sweep.
        for (int i = 0; i < N; i++) resp_col[i] = 4'hF;
        run_sweep("stale", 4'b1111);
        for (int i = 0; i < N; i++) resp_col[i] = 4'($urandom_range(1, 15));
        run_sweep("partial", 4'b0101);
        check_eq("partial.nib1", 32'(enemy_col[7:4]), 32'd0);
        check_eq("partial.nib3", 32'(enemy_col[15:12]), 32'd0);

        // Slot 1 stalled while its live state changes.
        set_defaults();
        stall_cyc[1] = 12;
        fork
            run_sweep("stall", 4'b1111);
            begin
                wait_query(1, ok);
                check_eq("stall.found", 32'(ok), 32'd1);
                for (int k = 0; k < 10; k++) begin
                    @(posedge sim_clk);
                    #1 enemy_state[32 +: 32] = $urandom;
                    @(negedge sim_clk);
                    check_eq("stall.q_valid", 32'(q_valid), 32'd1);
                    check_eq("stall.q_state", q_state, exp_state[1]);
                end
            end
        join
        enemy_state[32 +: 32] = exp_state[1];
        stall_cyc[1] = 0;

        // Lost response on slot 2, then the response-vs-timeout boundary.
        resp_dly[2] = 0;
        run_sweep("timeout", 4'b1111);
        check_eq("timeout.nib2", 32'(enemy_col[11:8]), 32'd0);
        pulse_clr();
        resp_dly[1] = T + 1;
        resp_dly[2] = T + 2;
        run_sweep("boundary", 4'b1111);
        pulse_clr();

        for (int s = 0; s < 8; s++) begin
            set_states();
            for (int i = 0; i < N; i++) begin
                resp_col[i]  = 4'($urandom);
                stall_cyc[i] = $urandom_range(0, 2);
                case ($urandom_range(0, 9))
                    0:       resp_dly[i] = 0;
                    1:       resp_dly[i] = T + 1;
                    2:       resp_dly[i] = T + 2;
                    default: resp_dly[i] = $urandom_range(1, 5);
                endcase
            end
            run_sweep("rand", 4'($urandom));
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        // Overrun during WAIT (with a simultaneous clear), then reset during slot 3.
        pulse_clr();
        set_defaults();
        for (int i = 0; i < N; i++) resp_dly[i] = 3;
        stall_cyc[3] = 5;
        q_log.delete();
        qs_log.delete();
        @(posedge sim_clk);
        #1;
        slot_en    = '1;
        s0         = step_cnt;
        frame_tick = 1'b1;
        @(posedge sim_clk);
        #1 frame_tick = 1'b0;
        @(posedge sim_clk);
        @(posedge sim_clk);
        #1;
        frame_tick = 1'b1;
        err_clr    = 1'b1;
        @(posedge sim_clk);
        #1;
        frame_tick = 1'b0;
        err_clr    = 1'b0;
        @(negedge sim_clk);
        check_eq("ovr.err_overrun", 32'(err_overrun), 32'd1);
        check_eq("ovr.busy", 32'(busy), 32'd1);
        wait_query(3, ok);
        check_eq("ovr.reached_slot3", 32'(ok), 32'd1);
        check_eq("ovr.n_queries", 32'(q_log.size()), 32'd3);
        for (int k = 0; k < q_log.size(); k++) check_eq("ovr.no_restart", 32'(q_log[k]), 32'(k));
        reset = 1'b0;
        repeat (2) @(negedge sim_clk);
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.q_valid", 32'(q_valid), 32'd0);
        check_eq("abort.enemy_col", 32'(enemy_col), 32'd0);
        check_eq("abort.err_overrun", 32'(err_overrun), 32'd0);
        @(posedge sim_clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge sim_clk);
        check_eq("abort.no_step", 32'(step_cnt - s0), 32'd0);
        check_eq("abort.idle", 32'(busy), 32'd0);
        check_eq("abort.col_after", 32'(enemy_col), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
